// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, read-engine states and test pattern.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACT       = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;

  localparam logic [11:0] ADDR_PRE_ALL   = 12'h400;
  localparam logic [8:0]  COL_LAST_BURST = 9'd508;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_ACT = 3'd2,
    RD_RD  = 3'd3,
    RD_PRE = 3'd4
  } rd_state_e;

  // Write engine's burst pattern, indexed by word position within a burst.
  localparam logic [3:0][15:0] TEST_PATTERN = {16'd8, 16'd3, 16'd4, 16'd5};

  function automatic logic [15:0] test_word(input logic [1:0] idx);
    return TEST_PATTERN[idx];
  endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read data capture: CAS-latency aligned valid/index pipeline, data register and
// optional pattern checker (enabled by SDRAM_READ_CHECK_EN).
module sdram_rd_capture
  import sdram_pkg::*;
#(
  parameter int CAS_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
`ifdef SDRAM_READ_CHECK_EN
  input  logic [1:0]  issue_idx,
  output logic        err,
`endif
  input  logic [15:0] dq_in,
  output logic [15:0] data,
  output logic        data_valid
);

  logic [CAS_LAT-1:0] vld_q, vld_d;
  logic [15:0]        data_q, data_d;
  logic               data_valid_q, data_valid_d;
  logic               cap;

  assign cap = vld_q[CAS_LAT-1];

`ifdef SDRAM_READ_CHECK_EN
  logic [CAS_LAT-1:0][1:0] idx_q, idx_d;
  logic                    err_q, err_d;

  always_comb begin
    idx_d = {idx_q[CAS_LAT-2:0], issue_idx};
    err_d = err_q | (cap && (dq_in != test_word(idx_q[CAS_LAT-1])));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  always_comb begin
    vld_d        = {vld_q[CAS_LAT-2:0], issue_valid};
    data_d       = cap ? dq_in : data_q;
    data_valid_d = cap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;

endmodule

// File: rtl/sdram_read.sv
// SDRAM read engine: arbitrated row activate, back-to-back burst-of-4 reads, refresh yield.
// Optional read-pattern checker is built when SDRAM_READ_CHECK_EN is defined.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int CAS_LAT  = 3,
  parameter int T_RCD    = 3,
  parameter int T_RP     = 3,
  parameter int LAST_ROW = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rd_trigger,
  output logic        read_req,
  input  logic        read_en,
  input  logic        ref_req,
  output logic        read_end_flag,
  output logic [3:0]  rd_cmd,
  output logic [11:0] rd_addr,
  output logic [1:0]  rd_bank_addr,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] rd_data,
  output logic        rd_data_valid,
  output logic        rd_err
);

  rd_state_e   state_q, state_d;
  logic [3:0]  timer_q, timer_d;
  logic [1:0]  burst_cnt_q, burst_cnt_d;
  logic [8:0]  col_addr_q, col_addr_d;
  logic [11:0] row_addr_q, row_addr_d;
  logic        done_q, done_d;
  logic        row_end, data_end, issue_valid;

  assign row_end      = (col_addr_q == COL_LAST_BURST);
  assign data_end     = row_end && (row_addr_q == 12'(LAST_ROW));
  assign issue_valid  = (state_q == RD_RD);
  assign rd_bank_addr = 2'b00;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    burst_cnt_d   = '0;
    col_addr_d    = col_addr_q;
    row_addr_d    = row_addr_q;
    done_d        = done_q;
    rd_cmd        = CMD_NOP;
    rd_addr       = '0;
    read_req      = 1'b0;
    read_end_flag = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_trigger) state_d = RD_REQ;
      end
      RD_REQ: begin
        read_req = 1'b1;
        if (read_en) begin
          state_d = RD_ACT;
          timer_d = 4'(T_RCD);
        end
      end
      RD_ACT: begin
        if (timer_q == 4'(T_RCD)) begin
          rd_cmd  = CMD_ACT;
          rd_addr = row_addr_q;
        end
        if (timer_q == '0) state_d = RD_RD;
        else               timer_d = timer_q - 4'd1;
      end
      RD_RD: begin
        burst_cnt_d = burst_cnt_q + 2'd1;
        if (burst_cnt_q == 2'd0) begin
          rd_cmd  = CMD_READ;
          rd_addr = {3'b000, col_addr_q};
        end
        // Leave only at a burst boundary so no burst is cut short.
        if (burst_cnt_q == 2'd3) begin
          col_addr_d = col_addr_q + 9'd4;
          if (row_end) row_addr_d = data_end ? 12'd0 : row_addr_q + 12'd1;
          if (data_end) done_d = 1'b1;
          if (row_end || ref_req) begin
            state_d = RD_PRE;
            timer_d = 4'(T_RP);
          end
        end
      end
      RD_PRE: begin
        if (timer_q == 4'(T_RP)) begin
          rd_cmd  = CMD_PRECHARGE;
          rd_addr = ADDR_PRE_ALL;
        end
        if (timer_q == '0) begin
          if (done_q) begin
            state_d       = IDLE;
            done_d        = 1'b0;
            read_end_flag = 1'b1;
          end else if (ref_req) begin
            state_d = RD_REQ;
          end else begin
            state_d = RD_ACT;
            timer_d = 4'(T_RCD);
          end
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      burst_cnt_q <= '0;
      col_addr_q  <= '0;
      row_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      burst_cnt_q <= burst_cnt_d;
      col_addr_q  <= col_addr_d;
      row_addr_q  <= row_addr_d;
      done_q      <= done_d;
    end
  end

  sdram_rd_capture #(.CAS_LAT(CAS_LAT)) u_capture (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .issue_valid (issue_valid),
`ifdef SDRAM_READ_CHECK_EN
    .issue_idx   (burst_cnt_q),
    .err         (rd_err),
`endif
    .dq_in       (sdram_dq_in),
    .data        (rd_data),
    .data_valid  (rd_data_valid)
  );

`ifndef SDRAM_READ_CHECK_EN
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_read.sv
// Self-checking bench for sdram_read: SDRAM read model feeding a scoreboard queue.
module tb_sdram_read;
  import sdram_pkg::*;

  localparam int CAS_LAT  = 3;
  localparam int T_RCD    = 3;
  localparam int T_RP     = 3;
  localparam int LAST_ROW = 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rd_trigger = 1'b0;
  logic        read_en = 1'b0;
  logic        ref_req = 1'b0;
  logic [15:0] sdram_dq_in = 16'h0;
  logic        read_req, read_end_flag, rd_data_valid, rd_err;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank_addr;
  logic [15:0] rd_data;

  always #5 sys_clk = ~sys_clk;

  sdram_read #(.CAS_LAT(CAS_LAT), .T_RCD(T_RCD), .T_RP(T_RP), .LAST_ROW(LAST_ROW)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .rd_trigger    (rd_trigger),
    .read_req      (read_req),
    .read_en       (read_en),
    .ref_req       (ref_req),
    .read_end_flag (read_end_flag),
    .rd_cmd        (rd_cmd),
    .rd_addr       (rd_addr),
    .rd_bank_addr  (rd_bank_addr),
    .sdram_dq_in   (sdram_dq_in),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_err        (rd_err)
  );

  int checks = 0, failures = 0, cyc = 0;
  int n_read = 0, n_act = 0, n_pre = 0, n_end = 0, n_valid = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sched_d[16];
  logic        sched_v[16];
  logic [8:0]  exp_col = '0;
  logic [11:0] exp_row = '0, cur_row = '0;
  logic        bad_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [11:0] row, input logic [8:0] col, input int k);
`ifdef SDRAM_READ_CHECK_EN
    if (bad_mode && k == 2) return 16'd7;
    return TEST_PATTERN[k[1:0]];
`else
    return {row[6:0], col + 9'(k)};
`endif
  endfunction

  always @(posedge sys_clk) cyc <= cyc + 1;

  // SDRAM model and scoreboard, sampled mid-cycle
  always @(negedge sys_clk) begin
    int slot;
    logic [15:0] w;
    if (sys_rst) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
      exp_col = '0;
      exp_row = '0;
      sdram_dq_in = 16'h0;
    end else begin
      if (rd_cmd == CMD_ACT) begin
        n_act++;
        chk("act_row", rd_addr, exp_row);
        cur_row = rd_addr;
      end else if (rd_cmd == CMD_READ) begin
        n_read++;
        chk("read_col", rd_addr, {3'b000, exp_col});
        for (int k = 0; k < 4; k++) begin
          w = model_word(cur_row, exp_col, k);
          slot = (cyc + CAS_LAT + k) % 16;
          sched_d[slot] = w;
          sched_v[slot] = 1'b1;
          exp_q.push_back(w);
        end
        if (exp_col == 9'd508) exp_row = (exp_row == 12'(LAST_ROW)) ? 12'd0 : exp_row + 12'd1;
        exp_col = exp_col + 9'd4;
      end else if (rd_cmd == CMD_PRECHARGE) begin
        n_pre++;
        chk("pre_addr", rd_addr, ADDR_PRE_ALL);
      end else begin
        chk("cmd_nop", rd_cmd, CMD_NOP);
      end
      if (read_end_flag) n_end++;
      slot = cyc % 16;
      sdram_dq_in = sched_v[slot] ? sched_d[slot] : 16'hBEEF;
      sched_v[slot] = 1'b0;
      if (rd_data_valid) begin
        n_valid++;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic start_read();
    rd_trigger = 1'b1;
    tick(1);
    rd_trigger = 1'b0;
    chk("read_req_up", read_req, 1);
    tick(1);
    read_en = 1'b1;
    tick(1);
    read_en = 1'b0;
  endtask

  task automatic wait_cmd(input logic [3:0] cmd, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (rd_cmd == cmd) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_read_col(input logic [11:0] col, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (rd_cmd == CMD_READ && rd_addr == col) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (read_end_flag) break;
    end
    chk("read_end_flag", read_end_flag, 1);
  endtask

  task automatic wait_read_req(input string tag);
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (read_req) break;
    end
    chk(tag, read_req, 1);
  endtask

  initial begin
    int c_act, c_rd, c_v, c_pre, n_hi, pre_snap;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_cmd", rd_cmd, CMD_NOP);
    chk("rst_addr", rd_addr, 0);
    chk("rst_bank", rd_bank_addr, 0);
    chk("rst_req", read_req, 0);
    chk("rst_end", read_end_flag, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_err", rd_err, 0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    tick(2);

    // Full region read, with first-burst latency checks
    start_read();
    wait_cmd(CMD_ACT, 10, c_act);
    chk("first_act", rd_cmd, CMD_ACT);
    wait_cmd(CMD_READ, 10, c_rd);
    chk("first_read", rd_cmd, CMD_READ);
    chk("act_to_read", c_rd - c_act, T_RCD + 1);
    c_v = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (rd_data_valid) begin
        c_v = cyc;
        break;
      end
    end
    chk("read_to_valid", c_v - c_rd, CAS_LAT + 1);
    n_hi = 0;
    repeat (4) begin
      if (rd_data_valid) n_hi++;
      @(negedge sys_clk);
    end
    chk("valid_run", n_hi, 4);
    @(posedge sys_clk);
    #1 rd_trigger = 1'b1;
    read_en = 1'b1;
    tick(1);
    rd_trigger = 1'b0;
    read_en = 1'b0;
    wait_end(3000);
    repeat (4) @(negedge sys_clk);
    chk("n_read", n_read, 256);
    chk("n_valid", n_valid, 1024);
    chk("n_act", n_act, 2);
    chk("n_pre", n_pre, 2);
    chk("n_end", n_end, 1);
    chk("sb_drained", exp_q.size(), 0);
    chk("idle_req", read_req, 0);

    // Refresh interruption mid-row, then refresh coinciding with row end
    @(posedge sys_clk);
    #1;
    start_read();
    wait_read_col(12'd64, 200, c_rd);
    chk("col64_seen", rd_addr, 64);
    @(posedge sys_clk);
    #1 ref_req = 1'b1;
    wait_cmd(CMD_PRECHARGE, 10, c_pre);
    chk("ref_pre_at_burst_end", c_pre - c_rd, 4);
    wait_read_req("ref_to_rd_req");
    @(posedge sys_clk);
    #1 ref_req = 1'b0;
    tick(1);
    read_en = 1'b1;
    tick(1);
    read_en = 1'b0;
    wait_cmd(CMD_ACT, 10, c_act);
    chk("ref_act_row", rd_addr, 0);
    wait_cmd(CMD_READ, 10, c_rd);
    chk("resume_col", rd_addr, 68);

    wait_read_col(12'd508, 600, c_rd);
    chk("col508_seen", rd_addr, 508);
    pre_snap = n_pre;
    @(posedge sys_clk);
    #1 ref_req = 1'b1;
    wait_cmd(CMD_PRECHARGE, 10, c_pre);
    wait_read_req("rowend_ref_rd_req");
    chk("rowend_one_pre", n_pre - pre_snap, 1);
    @(posedge sys_clk);
    #1 ref_req = 1'b0;
    read_en = 1'b1;
    tick(1);
    read_en = 1'b0;
    wait_cmd(CMD_ACT, 10, c_act);
    chk("rowend_act_row", rd_addr, 1);
    wait_cmd(CMD_READ, 10, c_rd);
    chk("rowend_col", rd_addr, 0);

    // Reset while reads and data are in flight
    for (int i = 0; i < 50; i++) begin
      @(posedge sys_clk);
      #1;
      if (rd_cmd == CMD_READ && rd_data_valid) break;
    end
    chk("pre_rst_valid", rd_data_valid, 1);
    sys_rst = 1'b1;
    #1;
    chk("rst_mid_cmd", rd_cmd, CMD_NOP);
    chk("rst_mid_valid", rd_data_valid, 0);
    tick(2);
    sys_rst = 1'b0;
    tick(1);
    start_read();
    wait_cmd(CMD_ACT, 10, c_act);
    chk("restart_row", rd_addr, 0);
    wait_cmd(CMD_READ, 10, c_rd);
    chk("restart_col", rd_addr, 0);
    wait_end(3000);
    repeat (4) @(negedge sys_clk);
    chk("sb_drained2", exp_q.size(), 0);

`ifdef SDRAM_READ_CHECK_EN
    chk("err_clean", rd_err, 0);
    bad_mode = 1'b1;
    @(posedge sys_clk);
    #1;
    start_read();
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (rd_data_valid) break;
    end
    for (int w = 0; w < 5; w++) begin
      chk("err_word", rd_err, (w >= 2) ? 1 : 0);
      @(negedge sys_clk);
    end
    repeat (20) @(negedge sys_clk);
    chk("err_sticky", rd_err, 1);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    chk("err_rst", rd_err, 0);
    bad_mode = 1'b0;
    tick(2);
    sys_rst = 1'b0;
`else
    chk("err_tied", rd_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_read.md
# sdram_read

Read-side engine of the SDRAM controller, the counterpart of the write engine. It requests bus ownership from the arbiter, activates a row, and issues back-to-back burst-of-4 READ commands across the column range. It captures returning data after the CAS latency and presents it as a valid-qualified stream. It yields to auto-refresh at burst boundaries and resumes where it stopped. It sits beside the write and refresh engines under the arbiter, and its rd_cmd/rd_addr/rd_bank_addr are muxed onto the SDRAM pins.

## Interface
- CAS_LAT, 3: CAS latency in cycles (2 or 3); must match the mode register.
- T_RCD, 3: NOP cycles after ACTIVE before the first READ.
- T_RP, 3: NOP cycles after PRECHARGE.
- LAST_ROW, 1: final row of the read region; data end is at column 511 of this row.

One clock; reset is asynchronous and active-high.
- sys_clk  in  1  controller clock; also the SDRAM clock.
- sys_rst  in  1  asynchronous, active-high reset.
- rd_trigger  in  1  single-cycle pulse that starts a read of the region.
- read_req  out  1  request to the arbiter; high whenever the state is RD_REQ.
- read_en  in  1  grant from the arbiter; sampled only in RD_REQ.
- ref_req  in  1  refresh pending from the refresh engine.
- read_end_flag  out  1  one-cycle pulse when the whole region has been read and precharged.
- rd_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}.
- rd_addr  out  12  SDRAM address bus.
- rd_bank_addr  out  2  constant 2'b00.
- sdram_dq_in  in  16  SDRAM data bus, input direction.
- rd_data  out  16  captured read word.
- rd_data_valid  out  1  rd_data is valid this cycle.
- rd_err  out  1  sticky pattern mismatch flag; only exists with SDRAM_READ_CHECK_EN.

## Operation
- States:
  - IDLE -> RD_REQ on rd_trigger.
  - RD_REQ -> RD_ACT on read_en.
  - RD_ACT -> RD_RD after T_RCD+1 cycles.
  - RD_RD -> RD_PRE at a burst end (burst_cnt==3) if any of these holds: data end, row end, or ref_req.
  - RD_PRE, after T_RP+1 cycles:
    - -> RD_REQ if ref_req and the read is unfinished.
    - -> RD_ACT if row end and the read is unfinished (row_addr already incremented).
    - -> IDLE with a read_end_flag pulse if data end.
  - Priority when several conditions hold at once: data end, then ref_req, then row end.
- Commands:
  - ACTIVE 0011: first RD_ACT cycle; rd_addr = row_addr.
  - READ 0101: when burst_cnt==0 in RD_RD; rd_addr = {3'b000, col_addr} (A10=0, no auto-precharge).
  - PRECHARGE 0010: first RD_PRE cycle; rd_addr = 12'h400 (all banks).
  - NOP 0111: all other cycles.
- Counters:
  - col_addr is 9 bits and advances by 4 per burst. The burst issued at column 508 is the row end; col_addr then wraps to 0.
  - row_addr is 12 bits, increments at row end, and is cleared at data end.
  - Row and column are retained across a refresh interruption, so the read resumes at the next unread burst.
- Data capture:
  - A READ issued at cycle t puts data on sdram_dq_in at t+CAS_LAT through t+CAS_LAT+3.
  - Data is registered, so rd_data_valid is high for exactly 4 consecutive cycles, t+CAS_LAT+1 through t+CAS_LAT+4.
  - Back-to-back bursts give continuous valid with no gaps.
- PRECHARGE is issued only on the cycle after the 4th cycle of the final burst, so no burst is truncated. Capture of in-flight data continues through RD_PRE and the following states.

## Timing
- Reset values:
  - rd_cmd = NOP; rd_addr = 0; rd_bank_addr = 0.
  - read_req = 0; read_end_flag = 0; rd_data = 0; rd_data_valid = 0; rd_err = 0.
  - State IDLE; all counters and the capture pipeline cleared.
- Reset mid-operation aborts immediately and discards in-flight data. No PRECHARGE is issued; the controller init sequence covers it.
- rd_trigger outside IDLE is ignored.
- read_en outside RD_REQ is ignored.
- ref_req arriving mid-burst takes effect only at that burst's end.
- Latency from grant to first valid word is 1 + (T_RCD+1) + CAS_LAT + 1 cycles.

## Configuration
- SDRAM_READ_CHECK_EN defined:
  - Each valid word is compared with the expected pattern by burst index: 5, 4, 3, 8 (the write engine's test pattern).
  - A mismatch sets rd_err, which stays set until sys_rst.
- SDRAM_READ_CHECK_EN undefined: no checker logic, and rd_err is tied to 0.

## Structure
- Shared package sdram_pkg: 4-bit CMD_NOP/ACT/READ/WRITE/PRECHARGE/AREF constants, the state encodings, the precharge-all address constant, and the test pattern array.
- Sub-module sdram_rd_capture: a CAS_LAT-deep valid/burst-index shift pipeline plus the data register and the optional checker.

## Test plan
- CAS_LAT=3, T_RCD=3: rd_trigger, then grant 2 cycles later.
  - ACTIVE appears, then the first READ 4 cycles after it.
  - rd_data_valid rises 4 cycles after that READ and stays high for 4 cycles with the model's data.
- Full region with LAST_ROW=1:
  - 256 READs in total, PRECHARGE+ACTIVE at the row boundary, row 1 read, then a read_end_flag pulse.
  - rd_data_valid count is exactly 1024.
- ref_req asserted during burst_cnt==1 at column 64:
  - Current burst finishes, PRECHARGE is issued, state goes to RD_REQ with read_req high.
  - After the grant, the first READ uses column 68.
- ref_req and row end on the same burst: one PRECHARGE, exit to RD_REQ; after the grant, ACTIVE uses the next row and the READ uses column 0.
- sys_rst asserted during RD_RD: rd_cmd is NOP and valid drops in the same cycle; a new rd_trigger restarts from row 0, column 0.
- With SDRAM_READ_CHECK_EN: the model returns 5,4,7,8; rd_err rises on the third valid word and stays high.
